// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - BIN, LSB first, with a start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             diff_bit;
    logic             br_next;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs plus last-cycle detect.
    always_comb begin
        diff_bit = sa[0] ^ sb[0] ^ br;
        br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Sequencer, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    res <= {diff_bit, res[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        // br here is the borrow into the MSB cell, br_next the borrow out of it.
                        d     <= {diff_bit, res[WIDTH-1:1]};
                        bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= br ^ br_next;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= SHIFT;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
